// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, FSM encoding and
// the doubleword alignment mask.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 64;

    // Low address bits that must be zero for a doubleword access.
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StWaitRd = 2'd2
    } state_e;

    function automatic logic misaligned(input logic [2:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX handshake, data-memory request/grant/rvalid sequencing,
// writeback and branch-redirect pulses. All outputs except ex_ready are registered.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD = WORD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [WORD-1:0] ex_alu_result,
    input  logic            ex_zero,
    input  logic [WORD-1:0] ex_store_data,
    input  logic [WORD-1:0] ex_branch_target,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_branch,
    input  logic            ex_uncond,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    output logic            dm_req,
    output logic            dm_we,
    output logic [WORD-1:0] dm_addr,
    output logic [WORD-1:0] dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [WORD-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [WORD-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            pc_src,
    output logic [WORD-1:0] pc_target,
    output logic            flush,
    output logic            mem_err
);

    state_e            state_q, state_d;
    logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [WORD-1:0]   dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
    logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [WORD-1:0]   wb_data_q, wb_data_d, pc_target_q, pc_target_d;
    logic [4:0]        wb_rd_q, wb_rd_d, rd_q, rd_d;
    logic              pc_src_q, pc_src_d, flush_q, flush_d, mem_err_q, mem_err_d;
    logic              reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;

    always_comb begin
        state_d        = state_q;
        dm_req_d       = dm_req_q;
        dm_we_d        = dm_we_q;
        dm_addr_d      = dm_addr_q;
        dm_wdata_d     = dm_wdata_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        pc_src_d       = 1'b0;
        flush_d        = 1'b0;
        pc_target_d    = pc_target_q;
        mem_err_d      = 1'b0;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        mem_to_reg_d   = mem_to_reg_q;

        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (ex_mem_read || ex_mem_write) begin
                        if ((ex_mem_read && ex_mem_write) || misaligned(ex_alu_result[2:0])) begin
                            // Illegal access: retire without touching memory or the register file.
                            mem_err_d  = 1'b1;
                            wb_valid_d = 1'b1;
                            wb_data_d  = ex_alu_result;
                            wb_rd_d    = ex_rd;
                        end else begin
                            state_d      = StReq;
                            dm_req_d     = 1'b1;
                            dm_we_d      = ex_mem_write;
                            dm_addr_d    = ex_alu_result;
                            dm_wdata_d   = ex_store_data;
                            rd_d         = ex_rd;
                            reg_write_d  = ex_reg_write;
                            mem_to_reg_d = ex_mem_to_reg;
                        end
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                        if (ex_uncond || (ex_branch && ex_zero)) begin
                            pc_src_d    = 1'b1;
                            flush_d     = 1'b1;
                            pc_target_d = ex_branch_target;
                        end
                    end
                end
            end
            StReq: begin
                if (dm_gnt) begin
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    if (dm_we_q) begin
                        state_d    = StIdle;
                        wb_valid_d = 1'b1;
                        wb_data_d  = dm_addr_q;
                        wb_rd_d    = rd_q;
                    end else if (dm_rvalid) begin
                        state_d        = StIdle;
                        wb_valid_d     = 1'b1;
                        wb_data_d      = mem_to_reg_q ? dm_rdata : dm_addr_q;
                        wb_rd_d        = rd_q;
                        wb_reg_write_d = reg_write_q;
                    end else begin
                        state_d = StWaitRd;
                    end
                end
            end
            StWaitRd: begin
                if (dm_rvalid) begin
                    state_d        = StIdle;
                    wb_valid_d     = 1'b1;
                    // dm_addr_q still holds the captured ALU result.
                    wb_data_d      = mem_to_reg_q ? dm_rdata : dm_addr_q;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = reg_write_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            pc_src_q       <= 1'b0;
            flush_q        <= 1'b0;
            pc_target_q    <= '0;
            mem_err_q      <= 1'b0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            dm_req_q       <= dm_req_d;
            dm_we_q        <= dm_we_d;
            dm_addr_q      <= dm_addr_d;
            dm_wdata_q     <= dm_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            pc_src_q       <= pc_src_d;
            flush_q        <= flush_d;
            pc_target_q    <= pc_target_d;
            mem_err_q      <= mem_err_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
        end
    end

    assign ex_ready     = rst_n && (state_q == StIdle);
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign pc_src       = pc_src_q;
    assign flush        = flush_q;
    assign pc_target    = pc_target_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writebacks, a
// negedge monitor pops and compares every wb_valid pulse.
module tb_mem_stage;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready, ex_zero;
    logic [63:0] ex_alu_result, ex_store_data, ex_branch_target;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_branch, ex_uncond, ex_reg_write, ex_mem_to_reg;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        wb_valid, wb_reg_write, pc_src, flush, mem_err;
    logic [63:0] wb_data, pc_target;
    logic [4:0]  wb_rd;

    mem_stage #(.WORD(64)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
        .ex_branch_target(ex_branch_target), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_uncond(ex_uncond),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .pc_src(pc_src), .pc_target(pc_target),
        .flush(flush), .mem_err(mem_err)
    );

    typedef struct {
        logic [63:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        err;
        logic        br;
        logic [63:0] target;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   req_cycles = 0;
    logic mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dm_req) req_cycles++;
            if (!wb_valid) begin
                chk("pulse_without_wb", {61'b0, pc_src, flush, mem_err}, 64'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_wb", {63'b0, wb_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                chk("wb_rd", {59'b0, wb_rd}, {59'b0, e.rd});
                chk("wb_reg_write", {63'b0, wb_reg_write}, {63'b0, e.reg_write});
                chk("mem_err", {63'b0, mem_err}, {63'b0, e.err});
                chk("pc_src", {63'b0, pc_src}, {63'b0, e.br});
                chk("flush", {63'b0, flush}, {63'b0, e.br});
                if (e.br) chk("pc_target", pc_target, e.target);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] data, input logic chk_data, input logic [4:0] rd,
                        input logic rw, input logic err, input logic br,
                        input logic [63:0] target);
        exp_t e;
        e.data = data; e.chk_data = chk_data; e.rd = rd; e.reg_write = rw;
        e.err = err; e.br = br; e.target = target;
        exp_q.push_back(e);
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_alu_result = '0; ex_zero = 0; ex_store_data = '0;
        ex_branch_target = '0; ex_rd = '0; ex_mem_read = 0; ex_mem_write = 0;
        ex_branch = 0; ex_uncond = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    endtask

    task automatic accept();
        int n = 0;
        while (!ex_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!ex_ready) chk("ready_timeout", {63'b0, ex_ready}, 64'd1);
        ex_valid = 1'b1;
        cyc();
        clear_ex();
    endtask

    task automatic alu_op(input logic [63:0] res, input logic [4:0] rd, input logic rw);
        clear_ex();
        ex_alu_result = res; ex_rd = rd; ex_reg_write = rw;
        accept();
    endtask

    task automatic mem_op(input logic [63:0] addr, input logic [63:0] data, input logic [4:0] rd,
                          input logic rd_en, input logic wr_en, input logic m2r, input logic rw);
        clear_ex();
        ex_alu_result = addr; ex_store_data = data; ex_rd = rd; ex_mem_read = rd_en;
        ex_mem_write = wr_en; ex_mem_to_reg = m2r; ex_reg_write = rw;
        accept();
    endtask

    task automatic br_op(input logic [63:0] target, input logic [63:0] alu, input logic [4:0] rd,
                         input logic br, input logic unc, input logic zero, input logic rw);
        clear_ex();
        ex_branch_target = target; ex_alu_result = alu; ex_rd = rd;
        ex_branch = br; ex_uncond = unc; ex_zero = zero; ex_reg_write = rw;
        accept();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dm_ctl"}, {62'b0, dm_req, dm_we}, 64'd0);
        chk({tag, "_dm_addr"}, dm_addr, 64'd0);
        chk({tag, "_dm_wdata"}, dm_wdata, 64'd0);
        chk({tag, "_wb_data"}, wb_data, 64'd0);
        chk({tag, "_wb_rd"}, {59'b0, wb_rd}, 64'd0);
        chk({tag, "_flags"}, {59'b0, wb_valid, wb_reg_write, pc_src, flush, mem_err}, 64'd0);
        chk({tag, "_pc_target"}, pc_target, 64'd0);
        chk({tag, "_ex_ready"}, {63'b0, ex_ready}, 64'd0);
    endtask

    initial begin
        clear_ex();
        rst_n = 0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
        cyc(); cyc();
        chk_reset_outputs("reset");
        mon_en = 1'b1;
        rst_n = 1;
        cyc();
        chk("ready_after_reset", {63'b0, ex_ready}, 64'd1);

        // ALU op, then two back-to-back
        push(64'h10, 1, 5'd3, 1, 0, 0, '0);
        alu_op(64'h10, 5'd3, 1);
        push(64'h20, 1, 5'd4, 1, 0, 0, '0);
        push(64'h0, 1, 5'd5, 0, 0, 0, '0);
        alu_op(64'h20, 5'd4, 1);
        alu_op(64'h0, 5'd5, 0);
        cyc();

        // Load 0x100: grant on third request cycle, rvalid three cycles after grant
        push(64'hDEADBEEF, 1, 5'd7, 1, 0, 0, '0);
        req_cycles = 0;
        mem_op(64'h100, '0, 5'd7, 1, 0, 1, 1);
        chk("ld_addr", dm_addr, 64'h100);
        chk("ld_we", {63'b0, dm_we}, 64'd0);
        chk("ld_ready_req0", {63'b0, ex_ready}, 64'd0);
        cyc(); chk("ld_ready_req1", {63'b0, ex_ready}, 64'd0);
        cyc(); chk("ld_ready_req2", {63'b0, ex_ready}, 64'd0);
        dm_gnt = 1; cyc(); dm_gnt = 0;
        chk("ld_req_dropped", {63'b0, dm_req}, 64'd0);
        chk("ld_ready_wait0", {63'b0, ex_ready}, 64'd0);
        cyc(); cyc();
        chk("ld_ready_wait2", {63'b0, ex_ready}, 64'd0);
        dm_rvalid = 1; dm_rdata = 64'hDEADBEEF; cyc(); dm_rvalid = 0; dm_rdata = '0;
        chk("ld_req_cycles", req_cycles, 64'd3);
        cyc();

        // Store 0x08 <- 0x55, granted on first request cycle
        push(64'h08, 0, 5'd9, 0, 0, 0, '0);
        req_cycles = 0;
        mem_op(64'h08, 64'h55, 5'd9, 0, 1, 0, 1);
        chk("st_we", {63'b0, dm_we}, 64'd1);
        chk("st_addr", dm_addr, 64'h08);
        chk("st_wdata", dm_wdata, 64'h55);
        dm_gnt = 1; cyc(); dm_gnt = 0;
        chk("st_ready_back", {63'b0, ex_ready}, 64'd1);
        chk("st_req_low", {63'b0, dm_req}, 64'd0);
        chk("st_req_cycles", req_cycles, 64'd1);

        // Zero-latency load: gnt and rvalid together
        push(64'hCAFEF00D, 1, 5'd10, 1, 0, 0, '0);
        mem_op(64'h18, '0, 5'd10, 1, 0, 1, 1);
        dm_gnt = 1; dm_rvalid = 1; dm_rdata = 64'hCAFEF00D; cyc();
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
        chk("zl_ready_back", {63'b0, ex_ready}, 64'd1);

        // Load with mem_to_reg=0 writes back the address/ALU result
        push(64'h20, 1, 5'd11, 1, 0, 0, '0);
        mem_op(64'h20, '0, 5'd11, 1, 0, 0, 1);
        dm_gnt = 1; cyc(); dm_gnt = 0;
        dm_rvalid = 1; dm_rdata = 64'h1234; cyc(); dm_rvalid = 0; dm_rdata = '0;

        // Stray rvalid while idle must be ignored
        dm_rvalid = 1; dm_rdata = 64'hBAD; cyc(); cyc(); dm_rvalid = 0; dm_rdata = '0;

        // Misaligned load and read+write conflict both error out without a request
        push('0, 0, 5'd12, 0, 1, 0, '0);
        req_cycles = 0;
        mem_op(64'h103, '0, 5'd12, 1, 0, 1, 1);
        cyc();
        chk("mis_req_cycles", req_cycles, 64'd0);
        push('0, 0, 5'd13, 0, 1, 0, '0);
        mem_op(64'h40, 64'h1, 5'd13, 1, 1, 0, 1);
        cyc();
        chk("rw_req_cycles", req_cycles, 64'd0);

        // Branches: CBZ taken, CBZ not taken, unconditional with link write
        push(64'h0, 1, 5'd0, 0, 0, 1, 64'h200);
        br_op(64'h200, 64'h0, 5'd0, 1, 0, 1, 0);
        push(64'h5, 1, 5'd0, 0, 0, 0, '0);
        br_op(64'h280, 64'h5, 5'd0, 1, 0, 0, 0);
        push(64'h44, 1, 5'd30, 1, 0, 1, 64'h300);
        br_op(64'h300, 64'h44, 5'd30, 0, 1, 0, 1);
        cyc();

        // Reset during WAIT_RD drops the load; late rvalid ignored
        mem_op(64'h48, '0, 5'd14, 1, 0, 1, 1);
        dm_gnt = 1; cyc(); dm_gnt = 0;
        chk("wr_in_wait", {63'b0, ex_ready}, 64'd0);
        rst_n = 0; cyc();
        chk_reset_outputs("midrst");
        rst_n = 1;
        dm_rvalid = 1; dm_rdata = 64'h77; cyc(); dm_rvalid = 0; dm_rdata = '0;
        cyc();
        chk("midrst_idle", {63'b0, ex_ready}, 64'd1);
        chk("midrst_no_wb", {63'b0, wb_valid}, 64'd0);

        cyc(); cyc();
        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
